// File: rtl/dot_product_mac_4bit.sv
// Two-stage unsigned multiply-accumulate producing one dot product per DEPTH beats.
// Results leave over a valid/ready handshake; backpressure freezes the whole pipe.
module dot_product_mac_4bit #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 2*DATA_W + $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              busy
);

  localparam int PROD_W = 2*DATA_W;
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH-1);

  logic              stall;
  logic              accept;
  logic              fire;
  logic              done;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] prod_r;
  logic              p_valid;
  logic              p_last;
  logic              first;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  base;
  logic [ACC_W-1:0]  sum;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~clear;
  assign accept   = in_valid & in_ready;
  // clear discards whatever sits in stage 1, so stage 2 must not consume it
  assign fire     = p_valid & ~stall & ~clear;
  assign done     = fire & p_last;
  assign base     = first ? '0 : acc;
  assign sum      = base + ACC_W'(prod_r);
  assign busy     = (cnt != '0) | p_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      prod_r  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      p_valid <= 1'b0;
    end else if (accept) begin
      prod_r  <= PROD_W'(a) * PROD_W'(b);
      p_valid <= 1'b1;
      p_last  <= (cnt == LAST);
      cnt     <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end else if (!stall) begin
      p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (clear) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (fire) begin
      if (p_last) begin
        first <= 1'b1;
      end else begin
        acc   <= sum;
        first <= 1'b0;
      end
    end
  end

  // a result completing in the handshake cycle keeps out_valid asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else if (done) begin
      result    <= sum;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/dot_product_mac_4bit.md
Name: dot_product_mac_4bit

Overview:
- Downstream consumer of the 4-bit registered 2:1 operand-select stage in the matrix multiplication datapath.
- Takes one pair of unsigned 4-bit operands per accepted beat and multiplies them.
- Accumulates DEPTH consecutive products into one dot-product result, i.e. one output matrix element.
- Delivers each result over a valid/ready handshake to the result writeback stage.

Parameters:
DATA_W, 4, operand width in bits (unsigned)
DEPTH, 4, products summed per result (dot-product length); legal range 1..256
ACC_W, 2*DATA_W+$clog2(DEPTH) (=10), result/accumulator width; guarantees no overflow

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair a/b valid this cycle
in_ready  output  1  block can accept operands this cycle
a  input  DATA_W  operand A (from select stage)
b  input  DATA_W  operand B (from select stage)
clear  input  1  synchronous flush of partial dot product
out_valid  output  1  result valid, held until taken
out_ready  input  1  downstream accepts result
result  output  ACC_W  completed dot product
busy  output  1  partial sum in progress (beat counter nonzero or pipeline occupied)

Behaviour:
- Reset (async, rst=1): beat counter, stage-1 product/valid/last, accumulator, result, out_valid all 0. in_ready=1 and busy=0 once rst deasserts.
- Definitions:
  - accept = in_valid & in_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall & ~clear (combinational).
- Stage 1, on accept:
  - prod_r <= a*b (2*DATA_W bits, unsigned).
  - p_valid <= 1.
  - p_last <= (cnt==DEPTH-1).
  - cnt <= cnt+1, wrapping to 0 after DEPTH-1.
  - With no accept and no stall: p_valid <= 0.
- Stage 2, when p_valid & ~stall:
  - sum = (first ? 0 : acc) + prod_r, zero-extended to ACC_W. first is set after reset, clear, or a p_last beat.
  - If p_last: result <= sum, out_valid <= 1, first <= 1.
  - Else: acc <= sum, first <= 0.
- Latency: last operand accepted at cycle t → out_valid high at t+2. Throughput is one beat per cycle; back-to-back vectors have no bubbles while out_ready=1.
- Output handshake:
  - out_valid stays high and result stays stable until a cycle with out_ready=1.
  - out_valid falls after that cycle unless a new p_last completes in the same cycle. In that case result updates and out_valid stays 1.
- Stall (out_valid & ~out_ready):
  - Stage 1, stage 2, cnt and acc all hold.
  - in_ready=0, so no operand is lost or duplicated.
- clear:
  - Zeroes cnt and p_valid, sets first=1, and discards the partial sum.
  - Takes priority over in_valid: no accept in the clear cycle.
  - Does not affect a pending out_valid/result.
- DEPTH=1: every accepted beat yields a result equal to a*b.
- busy = (cnt!=0) | p_valid.

Test Plan:
1. DEPTH=4, out_ready=1. Beats a=1,2,3,4 / b=5,6,7,8 on consecutive cycles → result=70, out_valid pulses exactly 2 cycles after the 4th accept.
2. All beats a=15, b=15 → result=900 (0x384), no truncation in 10 bits.
3. Two back-to-back vectors (test 1 data, then test 2 data), in_valid held high, out_ready=1 → result 70 then 900, out_valid 4 cycles apart, in_ready never drops.
4. Backpressure: out_ready=0 when result 70 appears, held 5 cycles → out_valid and result=70 held, in_ready=0. The next vector's beats stall and are not lost. Raise out_ready → next result=900 is correct.
5. Beats 1*5, 2*6 accepted, then clear for 1 cycle (in_valid high, not accepted), then vector a=1,1,1,1 / b=2,2,2,2 → result=8, busy=0 after output.
6. Assert rst asynchronously mid-vector after 2 beats → out_valid, result, busy go to 0 immediately without a clock edge. After release, test 1 vector → result=70.
